// File: rtl/graphic_box_unit.sv
// rtl/graphic_box_unit.sv - one scanline of a clipped, bordered, optionally hollow box
// Streams dx/data pixel writes under a ready handshake, one start/done per row.
module graphic_box_unit #(
  parameter int X_W      = 12,
  parameter int SCREEN_W = 320,
  parameter int COLOR_W  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [X_W-1:0]     dy,
  input  logic [X_W-1:0]     x0,
  input  logic [X_W-1:0]     y0,
  input  logic [X_W-1:0]     width,
  input  logic [X_W-1:0]     height,
  input  logic [X_W-1:0]     border,
  input  logic [COLOR_W-1:0] fg_color,
  input  logic [COLOR_W-1:0] bg_color,
  input  logic               fill_en,
  input  logic               ready,
  output logic [X_W-1:0]     dx,
  output logic               wr,
  output logic [COLOR_W-1:0] data,
  output logic               busy,
  output logic               done
);

  localparam int XW1 = X_W + 1;
  localparam logic [X_W:0] SCR_W    = XW1'(SCREEN_W);
  localparam logic [X_W:0] SCR_LAST = XW1'(SCREEN_W - 1);

  typedef enum logic [1:0] {IDLE, CHECK, DRAW, DONE} state_t;
  state_t state, state_nx;

  logic [X_W-1:0]     dy_r, x0_r, y0_r, w_r, h_r, b_r;
  logic [COLOR_W-1:0] fg_r, bg_r;
  logic               fill_r;
  logic [X_W:0]       end_x_r;
  logic               brow_r;

  // Every geometry sum is one bit wider than the operands so it never wraps.
  logic [X_W:0] dy_e, x0_e, y0_e, w_e, h_e, b_e, dx_e;
  logic [X_W:0] y_end, x_end, last_x, end_c;
  logic         row_in, brow_c, empty, bpix, advance, at_end;

  assign dy_e = {1'b0, dy_r};
  assign x0_e = {1'b0, x0_r};
  assign y0_e = {1'b0, y0_r};
  assign w_e  = {1'b0, w_r};
  assign h_e  = {1'b0, h_r};
  assign b_e  = {1'b0, b_r};
  assign dx_e = {1'b0, dx};

  assign y_end  = y0_e + h_e;
  assign x_end  = x0_e + w_e;
  assign last_x = x_end - 1'b1;
  assign end_c  = (last_x < SCR_W) ? last_x : SCR_LAST;
  assign row_in = (dy_e >= y0_e) && (dy_e < y_end);
  assign brow_c = (dy_e < y0_e + b_e) || (dy_e + b_e >= y_end);
  assign empty  = !row_in || (w_r == '0) || (h_r == '0) || (x0_e >= SCR_W);

  assign bpix   = brow_r || (dx_e < x0_e + b_e) || (dx_e + b_e >= x_end);
  assign at_end = (dx_e == end_x_r);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr       = 1'b0;
    data     = '0;
    busy     = (state != IDLE);
    done     = 1'b0;
    advance  = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = CHECK;
      CHECK: state_nx = empty ? DONE : DRAW;
      DRAW: begin
        wr   = bpix || fill_r;
        data = wr ? (bpix ? fg_r : bg_r) : '0;
        advance = !wr || ready;
        if (advance && at_end) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dy_r    <= '0;
      x0_r    <= '0;
      y0_r    <= '0;
      w_r     <= '0;
      h_r     <= '0;
      b_r     <= '0;
      fg_r    <= '0;
      bg_r    <= '0;
      fill_r  <= 1'b0;
      end_x_r <= '0;
      brow_r  <= 1'b0;
      dx      <= '0;
    end else begin
      if (state == IDLE && start) begin
        dy_r   <= dy;
        x0_r   <= x0;
        y0_r   <= y0;
        w_r    <= width;
        h_r    <= height;
        b_r    <= border;
        fg_r   <= fg_color;
        bg_r   <= bg_color;
        fill_r <= fill_en;
      end
      if (state == CHECK) begin
        end_x_r <= end_c;
        brow_r  <= brow_c;
        if (!empty) dx <= x0_r;
      end
      if (state == DRAW && advance && !at_end) dx <= dx + 1'b1;
    end
  end

endmodule

// File: doc/graphic_box_unit.md
# graphic_box_unit

Parametrised rectangle renderer for the scanline graphics pipeline. It draws one scanline of an axis-aligned box per `start`/`done` transaction and is the synthesizable successor of the single-bit behavioural graphic unit. The scanline sequencer supplies the current row `dy`. The unit streams `dx`/`data` pixel writes into the line buffer under a `ready` backpressure handshake. It adds multi-bit colour, clipping, border/hollow modes and empty-row early exit.

## Interface
- `X_W`, 12, width of all coordinate and size fields
- `SCREEN_W`, 320, visible line width; pixels at `dx >= SCREEN_W` are clipped
- `COLOR_W`, 4, colour index width
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a scanline; sampled only in IDLE
- `dy`  in  X_W  current row; latched on start
- `x0`, `y0`  in  X_W  box top-left corner; latched on start
- `width`, `height`  in  X_W  box size in pixels; latched on start
- `border`  in  X_W  border thickness; 0 means no border; latched on start
- `fg_color`  in  COLOR_W  border colour
- `bg_color`  in  COLOR_W  interior colour
- `fill_en`  in  1  1 = interior pixels written, 0 = hollow box
- `ready`  in  1  line buffer accepts the current write
- `dx`  out  X_W  current pixel column (registered)
- `wr`  out  1  pixel write valid
- `data`  out  COLOR_W  pixel colour, valid while `wr`=1
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at end of transaction

## Operation
- FSM states: IDLE, CHECK, DRAW, DONE.
- **IDLE**
  - `start`=1: latch `dy` and all geometry/colour inputs, go to CHECK.
  - `start` in any other state is ignored.
- **CHECK** (one cycle)
  - All sums are computed at X_W+1 bits; they never wrap.
  - `row_in` = (dy ≥ y0) && (dy < y0+height).
  - `end_x` = min(x0+width−1, SCREEN_W−1).
  - `brow` = (dy < y0+border) || (dy+border ≥ y0+height).
  - If !row_in, width==0, height==0 or x0 ≥ SCREEN_W: go to DONE with no writes.
  - Otherwise load `dx` ← x0 and go to DRAW.
- **DRAW**
  - A pixel is a border pixel when: brow, or dx < x0+border, or dx+border ≥ x0+width.
  - Border pixel: `wr`=1, `data`=fg_color.
  - Interior pixel with fill_en=1: `wr`=1, `data`=bg_color.
  - Interior pixel with fill_en=0: `wr`=0 and the pixel is skipped.
  - When `border`=0, every pixel is interior.
  - The pixel advances when (`wr` && `ready`) or !`wr`.
  - On advance: if dx==end_x go to DONE, else dx ← dx+1.
  - While `wr`=1 and `ready`=0: dx, wr and data hold unchanged.
- **DONE**: `done`=1 for one cycle, then IDLE. `dx` keeps its last value until the next CHECK.
- Reset (asserted at any time, including mid-DRAW): state → IDLE immediately. No partial transaction resumes and no `done` is issued for the aborted line.

## Timing
- Reset values:
  - `dx`=0, `wr`=0, `data`=0, `busy`=0, `done`=0.
  - All latched configuration = 0.
- `wr` and `data` are decoded from the state and registered values only; there is no combinational input-to-output path.
- `ready` affects only next-state logic.
- Transaction timeline, with `start` sampled at edge k:
  - CHECK occupies cycle k+1.
  - The first DRAW cycle is k+2.
  - With `ready` held at 1 and n = end_x−x0+1 columns, DRAW lasts n cycles and `done` is high in cycle k+2+n.
  - Every `ready`=0 cycle during a write adds exactly one cycle.
- Empty row (or any early-exit case): `done` is high in cycle k+2.
- `busy` is high from cycle k+1 through the `done` cycle inclusive.
- Back-to-back operation: `start` held high during the DONE cycle is not sampled. The earliest restart is sampled in the IDLE cycle that follows.

## Test plan
- **Fill:** x0=10, width=5, y0=20, height=4, border=0, fill_en=1, bg=3, dy=21, ready=1 → wr=1 at dx=10..14 with data=3, first write 2 cycles after start, done pulse in the following cycle, 5 writes total.
- **Outside row:** same box with dy=19, then dy=24 → zero writes, done 2 cycles after start, busy high for exactly 2 cycles.
- **Hollow border:** border=1, fill_en=0, fg=7, dy=21 → writes only at dx=10 and dx=14, data=7, done still 7 cycles after start. With dy=20 → 5 writes of 7 (top border row).
- **Clipping:** x0=318, width=10 → writes only at dx=318 and 319. With x0=320 → no writes, done at cycle k+2.
- **Backpressure:** ready=0 for 3 cycles while dx=12 → dx=12, wr=1, data stable throughout the stall, pixel 12 accepted exactly once, done delayed by 3 cycles.
- **Reset and ignored start:**
  - Pulse reset_n low at dx=12 → wr, dx, busy and done are 0 asynchronously.
  - After release, a new start completes a normal line.
  - A start asserted while busy is ignored.
